// File: rtl/writeback_if.sv
// Execute/cache/decode-facing bundle of the register-file writeback controller.
// The master modport is the environment; the slave modport is writeback_ctrl.
interface writeback_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        hazard;
  logic        rf_wr_en;
  logic [4:0]  rf_rd_sel;
  logic [31:0] rf_wr_data;
  logic        err;

  modport master (
    output ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_result, ex_funct3,
           ex_addr_lo, mem_ready, mem_rdata, rs1_sel, rs2_sel,
    input  ex_ready, hazard, rf_wr_en, rf_rd_sel, rf_wr_data, err
  );

  modport slave (
    input  ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_result, ex_funct3,
           ex_addr_lo, mem_ready, mem_rdata, rs1_sel, rs2_sel,
    output ex_ready, hazard, rf_wr_en, rf_rd_sel, rf_wr_data, err
  );
endinterface

// File: rtl/writeback_ctrl.sv
// Register-file write-port controller: retires ALU results in one cycle and
// formats cache load data after the mem_ready handshake, with load-use hazard flag.
module writeback_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  typedef enum logic [2:0] {
    F_LB  = 3'b000,
    F_LH  = 3'b001,
    F_LW  = 3'b010,
    F_LBU = 3'b100,
    F_LHU = 3'b101
  } load_kind_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [4:0]        pend_rd;
  logic [2:0]        pend_funct3;
  logic [1:0]        pend_addr_lo;

  // Alignment and opcode legality of a load request.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F_LB, F_LBU: load_legal = 1'b1;
      F_LH, F_LHU: load_legal = ~lo[0];
      F_LW:        load_legal = (lo == 2'b00);
      default:     load_legal = 1'b0;
    endcase
  endfunction

  // Extract and extend the addressed byte/halfword from the cache word.
  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F_LB:    format_load = {{24{b[7]}}, b};
      F_LBU:   format_load = {24'h0, b};
      F_LH:    format_load = {{16{h[15]}}, h};
      F_LHU:   format_load = {16'h0, h};
      default: format_load = word;
    endcase
  endfunction

  // NOTE: every output driven from always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    bus.ex_ready = (state == IDLE);
    bus.hazard   = 1'b0;
    if (state == WAIT_MEM && pend_rd != 5'd0)
      bus.hazard = (bus.rs1_sel == pend_rd) || (bus.rs2_sel == pend_rd);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      pend_rd        <= 5'd0;
      pend_funct3    <= 3'd0;
      pend_addr_lo   <= 2'd0;
      bus.rf_wr_en   <= 1'b0;
      bus.rf_rd_sel  <= 5'd0;
      bus.rf_wr_data <= 32'd0;
      bus.err        <= 1'b0;
    end else begin
      bus.rf_wr_en <= 1'b0;
      bus.err      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            if (!bus.ex_is_load) begin
              // Index/data only move on a real write so they hold otherwise.
              if (bus.ex_reg_write && bus.ex_rd != 5'd0) begin
                bus.rf_wr_en   <= 1'b1;
                bus.rf_rd_sel  <= bus.ex_rd;
                bus.rf_wr_data <= bus.ex_result;
              end
            end else if (load_legal(bus.ex_funct3, bus.ex_addr_lo)) begin
              pend_rd      <= bus.ex_rd;
              pend_funct3  <= bus.ex_funct3;
              pend_addr_lo <= bus.ex_addr_lo;
              wait_cnt     <= '0;
              state        <= WAIT_MEM;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end

        WAIT_MEM: begin
          // mem_ready takes priority over a timeout in the same cycle.
          if (bus.mem_ready) begin
            if (pend_rd != 5'd0) begin
              bus.rf_wr_en   <= 1'b1;
              bus.rf_rd_sel  <= pend_rd;
              bus.rf_wr_data <= format_load(pend_funct3, pend_addr_lo, bus.mem_rdata);
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed scoreboard bench for writeback_ctrl: expected writes are queued as
// stimulus is driven and matched (index, data, cycle) when rf_wr_en fires.
module tb_writeback_ctrl;

  localparam int MEM_TIMEOUT = 64;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_exp_t;

  logic        clk;
  logic        rst;
  writeback_if bus ();

  writeback_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int      n_checks = 0;
  int      n_pass   = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      wr_seen  = 0;
  int      err_seen = 0;
  int      exp_writes = 0;
  int      exp_errs   = 0;
  wr_exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [4:0] rd, input logic [31:0] data);
    wr_exp_t e;
    e.rd   = rd;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    exp_writes++;
  endtask

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.rf_wr_en) begin
      wr_exp_t e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.rf_rd_sel), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_rd_sel", 32'(bus.rf_rd_sel), 32'(e.rd));
        check("wr_data", bus.rf_wr_data, e.data);
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (!rst && bus.err) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.ex_valid     = 1'b0;
    bus.ex_reg_write = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.ex_result    = 32'd0;
    bus.ex_funct3    = 3'd0;
    bus.ex_addr_lo   = 2'd0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'd0;
    bus.rs1_sel      = 5'd0;
    bus.rs2_sel      = 5'd0;
  endtask

  task automatic alu_retire(input logic wr, input logic [4:0] rd, input logic [31:0] res);
    bus.ex_valid     = 1'b1;
    bus.ex_is_load   = 1'b0;
    bus.ex_reg_write = wr;
    bus.ex_rd        = rd;
    bus.ex_result    = res;
    if (wr && rd != 5'd0) push_write(rd, res);
    @(negedge clk);
    check("alu_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
  endtask

  // Accept a legal load, wait n_wait cycles, then deliver rdata.
  task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input int n_wait, input logic [31:0] rdata, input logic [31:0] exp_data);
    logic exp_haz;
    exp_haz          = (rd != 5'd0);
    bus.ex_valid     = 1'b1;
    bus.ex_is_load   = 1'b1;
    bus.ex_reg_write = 1'b1;
    bus.ex_rd        = rd;
    bus.ex_funct3    = f3;
    bus.ex_addr_lo   = lo;
    bus.ex_result    = 32'h5555_5555;
    tick();
    bus.ex_valid = 1'b0;
    for (int i = 0; i < n_wait; i++) begin
      bus.rs1_sel = (i % 2 == 0) ? rd : 5'd0;
      bus.rs2_sel = (i % 2 == 0) ? 5'd0 : rd;
      @(negedge clk);
      check("wait_ex_ready", 32'(bus.ex_ready), 32'd0);
      check("wait_hazard", 32'(bus.hazard), 32'(exp_haz));
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    if (rd != 5'd0) push_write(rd, exp_data);
    @(negedge clk);
    check("mem_ex_ready", 32'(bus.ex_ready), 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.rs1_sel   = rd;
    @(negedge clk);
    check("post_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("post_hazard", 32'(bus.hazard), 32'd0);
    tick();
  endtask

  task automatic bad_load(input logic [2:0] f3, input logic [1:0] lo, input string tag);
    bus.ex_valid     = 1'b1;
    bus.ex_is_load   = 1'b1;
    bus.ex_reg_write = 1'b1;
    bus.ex_rd        = 5'd4;
    bus.ex_funct3    = f3;
    bus.ex_addr_lo   = lo;
    exp_errs++;
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check({tag, "_err"}, 32'(bus.err), 32'd1);
    check({tag, "_wr_en"}, 32'(bus.rf_wr_en), 32'd0);
    check({tag, "_ex_ready"}, 32'(bus.ex_ready), 32'd1);
    tick();
    @(negedge clk);
    check({tag, "_err_drop"}, 32'(bus.err), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    check("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("rst_rd_sel", 32'(bus.rf_rd_sel), 32'd0);
    check("rst_wr_data", bus.rf_wr_data, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("rst_hazard", 32'(bus.hazard), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back ALU retires, then a non-writing one and an x0 target.
    alu_retire(1'b1, 5'd5, 32'hDEAD_BEEF);
    alu_retire(1'b1, 5'd6, 32'h1234_5678);
    alu_retire(1'b0, 5'd3, 32'hAAAA_AAAA);
    alu_retire(1'b1, 5'd0, 32'hBBBB_BBBB);
    idle_inputs();
    tick();
    @(negedge clk);
    check("hold_rd_sel", 32'(bus.rf_rd_sel), 32'd6);
    check("hold_wr_data", bus.rf_wr_data, 32'h1234_5678);

    // Load formatting with waits and byte/half lanes.
    load_op(3'b000, 2'd3, 5'd7, 4, 32'h8012_3456, 32'hFFFF_FF80);
    load_op(3'b101, 2'd2, 5'd7, 4, 32'h8012_3456, 32'h0000_8012);
    load_op(3'b100, 2'd1, 5'd8, 0, 32'h0000_F100, 32'h0000_00F1);
    load_op(3'b001, 2'd0, 5'd9, 1, 32'h1234_8001, 32'hFFFF_8001);
    load_op(3'b010, 2'd0, 5'd31, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load_op(3'b000, 2'd0, 5'd0, 3, 32'h0000_0080, 32'hFFFF_FF80);

    // Illegal / misaligned loads.
    bad_load(3'b010, 2'd1, "lw_mis");
    bad_load(3'b011, 2'd0, "f3_011");
    bad_load(3'b001, 2'd3, "lh_mis");
    bad_load(3'b110, 2'd0, "f3_110");

    // Timeout with mem_ready held low.
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1;
    bus.ex_rd = 5'd11; bus.ex_funct3 = 3'b010; bus.ex_addr_lo = 2'd0;
    tick();
    bus.ex_valid = 1'b0;
    exp_errs++;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      if (i == 0 || i == MEM_TIMEOUT - 1) check("to_ex_ready", 32'(bus.ex_ready), 32'd0);
      tick();
    end
    @(negedge clk);
    check("to_err", 32'(bus.err), 32'd1);
    check("to_ex_ready_idle", 32'(bus.ex_ready), 32'd1);
    check("to_wr_en", 32'(bus.rf_wr_en), 32'd0);
    tick();
    @(negedge clk);
    check("to_err_drop", 32'(bus.err), 32'd0);

    // mem_ready in the last allowed cycle wins over the timeout.
    load_op(3'b010, 2'd0, 5'd10, MEM_TIMEOUT - 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    // Reset while waiting: the pending load must be discarded.
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1;
    bus.ex_rd = 5'd12; bus.ex_funct3 = 3'b010; bus.ex_addr_lo = 2'd0;
    tick();
    bus.ex_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("rr_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("rr_rd_sel", 32'(bus.rf_rd_sel), 32'd0);
    check("rr_wr_data", bus.rf_wr_data, 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rr_wr_en", 32'(bus.rf_wr_en), 32'd0);
    tick();
    tick();

    check("write_count", 32'(wr_seen), 32'(exp_writes));
    check("err_count", 32'(err_seen), 32'(exp_errs));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
- Write-side controller for the CPU register file. It drives the file's single write port (rf_wr_en, rf_rd_sel, rf_wr_data) from retiring instructions.
- ALU results retire in one cycle. Loads wait for the data cache's ready handshake, then are byte/half/word formatted before writeback.
- Flags read-after-write hazards against a pending load so decode can stall.
- Sits between execute/cache and the register array.

Parameters:
- MEM_TIMEOUT, 64, cycles allowed in WAIT_MEM before abort; counter width is clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute presents a retiring instruction
- ex_ready  out  1  controller accepts ex_* this cycle
- ex_reg_write  in  1  instruction writes rd
- ex_is_load  in  1  instruction is a load
- ex_rd  in  5  destination register
- ex_result  in  32  ALU result
- ex_funct3  in  3  load type
- ex_addr_lo  in  2  load byte address bits [1:0]
- mem_ready  in  1  cache read data valid
- mem_rdata  in  32  cache read word
- rs1_sel  in  5  decode source 1
- rs2_sel  in  5  decode source 2
- hazard  out  1  source matches pending load rd
- rf_wr_en  out  1  register file write enable
- rf_rd_sel  out  5  register file write index
- rf_wr_data  out  32  register file write data
- err  out  1  one-cycle pulse on misaligned/illegal load or timeout

Behaviour:
- Reset values: rf_wr_en=0, rf_rd_sel=0, rf_wr_data=0, err=0, state=IDLE, timeout counter=0, pending rd=0.
- A reset in WAIT_MEM discards the pending load; no write occurs.
- States are IDLE and WAIT_MEM.
- ex_ready is 1 in IDLE and 0 in WAIT_MEM. It is combinational.
- rf_* and err are registered. A write reaches the register file one cycle after acceptance, or one cycle after mem_ready.
- rf_wr_en is a single-cycle pulse and is 0 in all other cycles. rf_rd_sel and rf_wr_data hold their last values when rf_wr_en=0.
- IDLE, ex_valid, !ex_is_load:
  - Next cycle rf_wr_en = ex_reg_write && (ex_rd != 0), with rf_rd_sel=ex_rd and rf_wr_data=ex_result.
  - Stay in IDLE; back-to-back retires run at 1 per cycle.
- IDLE, ex_valid, ex_is_load:
  - Legal cases: funct3 000/100 at any alignment; 001/101 with addr_lo[0]=0; 010 with addr_lo=00.
  - Legal: capture rd, funct3 and addr_lo, clear the counter, go to WAIT_MEM.
  - Otherwise (misaligned, or funct3 011/110/111): next cycle err=1, no write, stay in IDLE.
- WAIT_MEM, mem_ready=1:
  - Next cycle rf_wr_en = (pending rd != 0), with formatted data.
  - Return to IDLE; a new ex_valid is accepted from that next cycle.
- WAIT_MEM, mem_ready=0: counter increments. When counter == MEM_TIMEOUT-1 without mem_ready, next cycle err=1, no write, return to IDLE.
- If mem_ready and the timeout hit occur in the same cycle, mem_ready wins and the write occurs.
- mem_ready is ignored in IDLE.
- Load formatting (byte lane = addr_lo):
  - LB: sign-extend mem_rdata[8*lane+7:8*lane].
  - LBU: zero-extend the same byte.
  - LH: sign-extend the halfword selected by addr_lo[1] (bits 15:0 or 31:16).
  - LHU: zero-extend the same halfword.
  - LW: the full word.
- hazard (combinational) = state==WAIT_MEM && pending rd != 0 && (rs1_sel == pending rd || rs2_sel == pending rd).
  - hazard is 0 in IDLE, including the writeback cycle. The register file read path sees the written value on the following cycle, and decode owns bypass of the in-flight rf_wr_data.
- Writes to x0 never assert rf_wr_en.

Test Plan:
- ALU retire: ex_valid, reg_write=1, rd=5, result=0xDEADBEEF -> next cycle rf_wr_en=1, rf_rd_sel=5, rf_wr_data=0xDEADBEEF; a second retire on the following cycle writes on the cycle after.
- LB with addr_lo=3, mem_rdata=0x80123456 delivered after 4 wait cycles, rd=7 -> ex_ready=0 for 5 cycles; hazard=1 while rs1_sel=7; write 0xFFFFFF80 to x7 one cycle after mem_ready. The same stimulus with LHU, addr_lo=2 writes 0x00008012.
- Misaligned LW at addr_lo=01 -> err pulses 1 cycle, no rf_wr_en, ex_ready stays 1. The same applies for funct3=011.
- Load with MEM_TIMEOUT=64 and mem_ready held 0 -> err pulses once after 64 wait cycles, no write, state returns to IDLE. In a second run, mem_ready arrives in the final cycle -> write occurs, no err.
- x0 destination: ALU retire and load with rd=0 -> rf_wr_en never asserted, and hazard stays 0 while rs1_sel=0.
- rst asserted while in WAIT_MEM, with mem_ready arriving the next cycle -> no write, all outputs 0, ex_ready=1 after reset.
